pad_rst_boot_ctrl: RTL

PAD_RST_BOOT_CTRL -- requirements
Module: pad_rst_boot_ctrl

---
 rtl/pad_rst_pkg.sv | 20 ++
 rtl/pad_sync.sv | 23 ++
 rtl/pad_rst_boot_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pad_rst_pkg.sv
// Shared types and default constants for the pad reset / boot-strap controller.
package pad_rst_pkg;

    typedef enum logic [1:0] {
        StAssert   = 2'd0,
        StDebounce = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam int unsigned SyncStagesDef     = 2;
    localparam int unsigned DebounceCyclesDef = 1000;
    localparam int unsigned HoldCyclesDef     = 16;
    localparam int unsigned GlitchCntW        = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pad_sync.sv
// N-stage single-bit synchronizer for raw pad inputs, synchronous active-high reset.
module pad_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[Stages-2:0], d_i};
        end
    end

    assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/pad_rst_boot_ctrl.sv
// Debounces the external reset pad, stretches the release and latches boot straps.
// Optional glitch counter output enabled by defining PAD_RST_GLITCH_CNT_EN.
module pad_rst_boot_ctrl
    import pad_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned HOLD_CYCLES     = HoldCyclesDef
) (
    input  logic                  ref_clk_i,
    input  logic                  rst_i,
    input  logic                  pad_rstn_i,
    input  logic                  pad_bootsel_i,
    input  logic                  pad_stm_i,
    output logic                  rstn_o,
    output logic                  bootsel_o,
    output logic                  stm_o,
`ifdef PAD_RST_GLITCH_CNT_EN
    output logic [GlitchCntW-1:0] glitch_cnt_o,
`endif
    output logic [1:0]            state_o
);

    localparam int unsigned CntW = $clog2(max_u(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);

    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    // The ASSERT->DEBOUNCE edge is the first stable sample, so DEBOUNCE stops one short.
    localparam logic [CntW-1:0] DebEnd   =
        (DEBOUNCE_CYCLES >= 2) ? CntW'(DEBOUNCE_CYCLES - 2) : '0;

    logic rst_s;
    logic boot_s;
    logic stm_s;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rstn_q;
    logic            boot_q;
    logic            stm_q;
    logic            strap_ld;

    pad_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_rst (
        .clk_i (ref_clk_i),
        .rst_i (rst_i),
        .d_i   (pad_rstn_i),
        .q_o   (rst_s)
    );

    pad_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_boot (
        .clk_i (ref_clk_i),
        .rst_i (rst_i),
        .d_i   (pad_bootsel_i),
        .q_o   (boot_s)
    );

    pad_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_stm (
        .clk_i (ref_clk_i),
        .rst_i (rst_i),
        .d_i   (pad_stm_i),
        .q_o   (stm_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strap_ld = 1'b0;
        unique case (state_q)
            StAssert: begin
                cnt_d = '0;
                if (rst_s) begin
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (!rst_s) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                end else if (cnt_q == DebEnd) begin
                    state_d  = StHold;
                    cnt_d    = '0;
                    strap_ld = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                // Pad level is ignored here so the hold period always completes.
                if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (rst_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StAssert;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q <= StAssert;
            cnt_q   <= '0;
            rstn_q  <= 1'b0;
            boot_q  <= 1'b0;
            stm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rstn_q  <= (state_d == StRun);
            if (strap_ld) begin
                boot_q <= boot_s;
                stm_q  <= stm_s;
            end
        end
    end

    assign rstn_o    = rstn_q;
    assign bootsel_o = boot_q;
    assign stm_o     = stm_q;
    assign state_o   = state_q;

`ifdef PAD_RST_GLITCH_CNT_EN
    logic                  glitch;
    logic [GlitchCntW-1:0] glitch_cnt_q;

    // A rejected pulse: release lost during debounce, or a short low run while running.
    assign glitch = ((state_q == StDebounce) && !rst_s) ||
                    ((state_q == StRun) && rst_s && (cnt_q != '0));

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            glitch_cnt_q <= '0;
        end else if (glitch && (glitch_cnt_q != '1)) begin
            glitch_cnt_q <= glitch_cnt_q + GlitchCntW'(1);
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule
